// File: rtl/programm_lader.sv
// UART program loader: receives a length-prefixed word stream, writes it into
// the instruction RAM and then releases the CPU from reset.
module programm_lader #(
   parameter int CLKS_PER_BIT = 217,
   parameter int WORDS        = 256,
   parameter int HALTEZYKLEN  = 10
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        UartRx,
   output logic [31:0] InstruktionAdresse,
   output logic [31:0] InstruktionRAMEingang,
   output logic        BeschreibeInstruktionRAM,
   output logic        InstruktionInitialisierung,
   output logic        CPUReset,
   output logic        Fertig,
   output logic        Fehler
);

   localparam int HALB = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
   localparam int ZW   = $clog2(CLKS_PER_BIT + 1);
   localparam int AW   = $clog2(WORDS + 1);
   localparam int HW   = $clog2(HALTEZYKLEN + 1);

   typedef enum logic [1:0] {EMPF_RUHE, EMPF_START, EMPF_DATEN, EMPF_STOP} empfZustand_t;
   typedef enum logic [2:0] {LAENGE0, LAENGE1, DATEN, SCHREIBEN, HALTEN, LAUF, FEHLER} ladeZustand_t;

   // Reset asserts asynchronously but releases only after two clean edges.
   logic [1:0] resetSync;
   logic       aktiv;
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) resetSync <= '0;
      else        resetSync <= {resetSync[0], 1'b1};
   end
   assign aktiv = resetSync[1];

   logic [1:0] rxSync;
   logic       rx;
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)     rxSync <= 2'b11;
      else if (aktiv) rxSync <= {rxSync[0], UartRx};
   end
   assign rx = rxSync[1];

   empfZustand_t empfZustand, empfNaechst;
   logic [ZW-1:0] takt, taktNaechst;
   logic [2:0]    bitZaehler, bitNaechst;
   logic [7:0]    schieber, schieberNaechst;
   logic          byteGueltig, byteGueltigNaechst;
   logic          rahmenFehler, rahmenFehlerNaechst;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      empfNaechst         = empfZustand;
      taktNaechst         = takt;
      bitNaechst          = bitZaehler;
      schieberNaechst     = schieber;
      byteGueltigNaechst  = 1'b0;
      rahmenFehlerNaechst = 1'b0;
      case (empfZustand)
         EMPF_RUHE: if (!rx) begin
            empfNaechst = EMPF_START;
            taktNaechst = '0;
         end
         EMPF_START: if (takt == ZW'(HALB - 1)) begin
            taktNaechst = '0;
            bitNaechst  = '0;
            empfNaechst = rx ? EMPF_RUHE : EMPF_DATEN;
         end else taktNaechst = takt + ZW'(1);
         EMPF_DATEN: if (takt == ZW'(CLKS_PER_BIT - 1)) begin
            taktNaechst     = '0;
            schieberNaechst = {rx, schieber[7:1]};
            if (bitZaehler == 3'd7) empfNaechst = EMPF_STOP;
            else                    bitNaechst  = bitZaehler + 3'd1;
         end else taktNaechst = takt + ZW'(1);
         EMPF_STOP: if (takt == ZW'(CLKS_PER_BIT - 1)) begin
            empfNaechst         = EMPF_RUHE;
            byteGueltigNaechst  = rx;
            rahmenFehlerNaechst = !rx;
         end else taktNaechst = takt + ZW'(1);
         default: empfNaechst = EMPF_RUHE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         empfZustand  <= EMPF_RUHE;
         takt         <= '0;
         bitZaehler   <= '0;
         schieber     <= '0;
         byteGueltig  <= 1'b0;
         rahmenFehler <= 1'b0;
      end else if (aktiv) begin
         empfZustand  <= empfNaechst;
         takt         <= taktNaechst;
         bitZaehler   <= bitNaechst;
         schieber     <= schieberNaechst;
         byteGueltig  <= byteGueltigNaechst;
         rahmenFehler <= rahmenFehlerNaechst;
      end
   end

   ladeZustand_t  zustand, zustandNaechst;
   logic [15:0]   laenge, laengeNaechst, laengeNeu;
   logic [AW-1:0] adresse, adresseNaechst;
   logic [31:0]   eingang, eingangNaechst;
   logic [1:0]    byteLane, byteLaneNaechst;
   logic [HW-1:0] halteZaehler, halteNaechst;

   assign laengeNeu = {schieber, laenge[7:0]};

   always_comb begin
      zustandNaechst  = zustand;
      laengeNaechst   = laenge;
      adresseNaechst  = adresse;
      eingangNaechst  = eingang;
      byteLaneNaechst = byteLane;
      halteNaechst    = halteZaehler;
      case (zustand)
         LAENGE0:
            if (rahmenFehler) zustandNaechst = FEHLER;
            else if (byteGueltig) begin
               laengeNaechst  = {8'h00, schieber};
               zustandNaechst = LAENGE1;
            end
         LAENGE1:
            if (rahmenFehler) zustandNaechst = FEHLER;
            else if (byteGueltig) begin
               laengeNaechst   = laengeNeu;
               byteLaneNaechst = '0;
               halteNaechst    = '0;
               if (laengeNeu == 16'd0)                zustandNaechst = HALTEN;
               else if (32'(laengeNeu) > 32'(WORDS))  zustandNaechst = FEHLER;
               else                                   zustandNaechst = DATEN;
            end
         DATEN:
            if (rahmenFehler) zustandNaechst = FEHLER;
            else if (byteGueltig) begin
               eingangNaechst[8*byteLane +: 8] = schieber;
               byteLaneNaechst = byteLane + 2'd1;
               if (byteLane == 2'd3) zustandNaechst = SCHREIBEN;
            end
         SCHREIBEN: begin
            adresseNaechst = adresse + AW'(1);
            halteNaechst   = '0;
            if (rahmenFehler)                                  zustandNaechst = FEHLER;
            else if (32'(adresse) + 32'd1 == 32'(laenge))      zustandNaechst = HALTEN;
            else                                               zustandNaechst = DATEN;
         end
         HALTEN:
            if (halteZaehler == HW'(HALTEZYKLEN - 1)) zustandNaechst = LAUF;
            else halteNaechst = halteZaehler + HW'(1);
         default: ;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         zustand      <= LAENGE0;
         laenge       <= '0;
         adresse      <= '0;
         eingang      <= '0;
         byteLane     <= '0;
         halteZaehler <= '0;
      end else if (aktiv) begin
         zustand      <= zustandNaechst;
         laenge       <= laengeNaechst;
         adresse      <= adresseNaechst;
         eingang      <= eingangNaechst;
         byteLane     <= byteLaneNaechst;
         halteZaehler <= halteNaechst;
      end
   end

   assign InstruktionAdresse         = 32'(adresse);
   assign InstruktionRAMEingang      = eingang;
   assign BeschreibeInstruktionRAM   = (zustand == SCHREIBEN);
   assign CPUReset                   = (zustand != LAUF);
   assign InstruktionInitialisierung = (zustand != LAUF);
   assign Fertig                     = (zustand == LAUF);
   assign Fehler                     = (zustand == FEHLER);

endmodule
